load_store_unit: RTL and testbench

Initiator-side front end for the 64-bit big-endian `DataMemory` block. It accepts one load or store request at a time from the execute stage and turns byte/half/word/doubleword accesses into naturally aligned doubleword accesses on the memory's `MemRead`/`MemWrite` port. Sub-doubleword stores use read-modify-write. Load results are sign- or zero-extended before they are returned. The block sits between the pipeline's memory stage and `DataMemory`, and is the only driver of the memory's port.

---
 rtl/load_store_unit.sv | 186 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store front end for the 64-bit big-endian DataMemory: sub-doubleword stores use read-modify-write.
// Optional misaligned-access trapping is compiled in with `define LSU_ALIGN_CHECK_EN.
module load_store_unit #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  output logic              resp_valid,
  output logic [63:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [63:0]       mem_write_data,
  output logic              MemRead,
  output logic              MemWrite,
  input  logic [63:0]       mem_read_data
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic              r_we;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic [ADDR_W-1:0] r_base;
  logic [2:0]        r_off;
  logic [63:0]       r_wdata;
  logic [63:0]       r_buf;
  logic              r_err;

  logic              w_accept;
  logic [2:0]        w_align_mask;
  logic [2:0]        w_off_eff;
  logic              w_misaligned;

  logic [3:0]        w_nbytes;
  logic [2:0]        w_rsh_bytes;
  logic [5:0]        w_shamt;
  logic [63:0]       w_lane_lo;
  logic [63:0]       w_lane_mask;
  logic [63:0]       w_merged;
  logic [63:0]       w_lane;
  logic              w_sign;
  logic [63:0]       w_load_ext;

  assign w_accept = req_valid && (r_state == S_IDLE);

  // Offset bits that must be zero for a naturally aligned access of each size.
  always_comb begin
    w_align_mask = 3'b111;
    case (req_size)
      2'b00:   w_align_mask = 3'b111;
      2'b01:   w_align_mask = 3'b110;
      2'b10:   w_align_mask = 3'b100;
      default: w_align_mask = 3'b000;
    endcase
`ifdef LSU_ALIGN_CHECK_EN
    w_misaligned = |(req_addr[2:0] & ~w_align_mask);
    w_off_eff    = req_addr[2:0];
`else
    w_misaligned = 1'b0;
    w_off_eff    = req_addr[2:0] & w_align_mask;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_misaligned)                     w_next = S_RESP;
          else if (req_we && req_size == 2'b11) w_next = S_WRITE;
          else                                  w_next = S_READ;
        end
      end
      S_READ:  w_next = r_we ? S_WRITE : S_RESP;
      S_WRITE: w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_we       <= 1'b0;
      r_size     <= '0;
      r_unsigned <= 1'b0;
      r_base     <= '0;
      r_off      <= '0;
      r_wdata    <= '0;
      r_buf      <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we       <= req_we;
        r_size     <= req_size;
        r_unsigned <= req_unsigned;
        r_base     <= {req_addr[ADDR_W-1:3], 3'b000};
        r_off      <= w_off_eff;
        r_wdata    <= req_wdata;
        r_err      <= w_misaligned;
      end
      if (r_state == S_READ) begin
        r_buf <= mem_read_data;
      end
    end
  end

  // Lane position counted from the LSB: bytes to the right of the lane, times 8.
  always_comb begin
    w_nbytes  = 4'd8;
    w_lane_lo = '1;
    w_sign    = 1'b0;
    case (r_size)
      2'b00:   begin w_nbytes = 4'd1; w_lane_lo = 64'h0000_0000_0000_00FF; end
      2'b01:   begin w_nbytes = 4'd2; w_lane_lo = 64'h0000_0000_0000_FFFF; end
      2'b10:   begin w_nbytes = 4'd4; w_lane_lo = 64'h0000_0000_FFFF_FFFF; end
      default: begin w_nbytes = 4'd8; w_lane_lo = '1;                      end
    endcase
    w_rsh_bytes = 3'(4'd8 - {1'b0, r_off} - w_nbytes);
    w_shamt     = {w_rsh_bytes, 3'b000};
    w_lane_mask = w_lane_lo << w_shamt;
    w_merged    = (r_buf & ~w_lane_mask) | ((r_wdata & w_lane_lo) << w_shamt);
    w_lane      = (r_buf >> w_shamt) & w_lane_lo;
    case (r_size)
      2'b00:   w_sign = w_lane[7];
      2'b01:   w_sign = w_lane[15];
      2'b10:   w_sign = w_lane[31];
      default: w_sign = w_lane[63];
    endcase
    w_load_ext = (w_sign && !r_unsigned) ? (w_lane | ~w_lane_lo) : w_lane;
  end

  always_comb begin
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    resp_rdata     = '0;
    resp_err       = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    MemRead        = 1'b0;
    MemWrite       = 1'b0;
    case (r_state)
      S_IDLE: req_ready = 1'b1;
      S_READ: begin
        MemRead     = !reset;
        mem_address = r_base;
      end
      S_WRITE: begin
        MemWrite       = !reset;
        mem_address    = r_base;
        mem_write_data = (r_size == 2'b11) ? r_wdata : w_merged;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_rdata = (!r_we && !r_err) ? w_load_ext : '0;
`ifdef LSU_ALIGN_CHECK_EN
        resp_err   = r_err;
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array DataMemory model, vector table, scoreboard queue of expected responses.
// Expectations for misaligned accesses follow whether LSU_ALIGN_CHECK_EN is defined.
module tb_load_store_unit;

  localparam int unsigned AW = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [AW-1:0] req_addr;
  logic [63:0]   req_wdata;
  logic          resp_valid;
  logic [63:0]   resp_rdata;
  logic          resp_err;
  logic [AW-1:0] mem_address;
  logic [63:0]   mem_write_data;
  logic          MemRead;
  logic          MemWrite;
  logic [63:0]   mem_read_data;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(AW)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_size       (req_size),
    .req_unsigned   (req_unsigned),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .MemRead        (MemRead),
    .MemWrite       (MemWrite),
    .mem_read_data  (mem_read_data)
  );

  // DataMemory model: 128 big-endian doublewords.
  logic [63:0] mem [128];
  initial for (int i = 0; i < 128; i++) mem[i] = '0;
  assign mem_read_data = MemRead ? mem[mem_address[AW-1:3]] : '0;
  always @(posedge clk) if (MemWrite) mem[mem_address[AW-1:3]] <= mem_write_data;

  typedef struct {
    logic          we;
    logic [1:0]    size;
    logic          uns;
    logic [AW-1:0] addr;
    logic [63:0]   wdata;
    logic [63:0]   rdata;
    logic          err;
  } vec_t;

  typedef struct {
    logic [63:0]   rdata;
    logic          err;
    int unsigned   lat;
    int unsigned   nrd;
    int unsigned   nwr;
    logic [AW-1:0] base;
    int unsigned   acc;
  } exp_t;

  exp_t        q[$];
  exp_t        cur_exp;
  vec_t        tbl[$];
  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned nrd_seen = 0;
  int unsigned nwr_seen = 0;
  logic        prev_resp = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t mkv(input logic we, input logic [1:0] size, input logic uns,
                               input logic [AW-1:0] addr, input logic [63:0] wdata,
                               input logic [63:0] rdata, input logic err);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr;
    v.wdata = wdata; v.rdata = rdata; v.err = err;
    return v;
  endfunction

  function automatic exp_t mk_exp(input vec_t v);
    exp_t e;
    e.rdata = v.rdata;
    e.err   = v.err;
    e.lat   = v.err ? 1 : ((v.we && v.size != 2'b11) ? 3 : 2);
    e.nrd   = v.err ? 0 : ((!v.we || v.size != 2'b11) ? 1 : 0);
    e.nwr   = v.err ? 0 : (v.we ? 1 : 0);
    e.base  = {v.addr[AW-1:3], 3'b000};
    e.acc   = 0;
    return e;
  endfunction

  // Monitor: everything sampled on the falling edge, away from state updates.
  initial forever begin
    exp_t e;
    @(negedge clk);
    cyc++;
    if (reset) begin
      q.delete();
      nrd_seen  = 0;
      nwr_seen  = 0;
      prev_resp = 1'b0;
    end else begin
      if (prev_resp) chk("ready_after_resp", 64'(req_ready), 64'd1);
      prev_resp = resp_valid;
      if (q.size() > 0) begin
        chk("busy_ready", 64'(req_ready), 64'd0);
        if (MemRead) begin
          nrd_seen++;
          chk("rd_addr", 64'(mem_address), 64'(q[0].base));
        end
        if (MemWrite) begin
          nwr_seen++;
          chk("wr_addr", 64'(mem_address), 64'(q[0].base));
        end
        if (resp_valid) begin
          e = q.pop_front();
          chk("rdata", resp_rdata, e.rdata);
          chk("err", 64'(resp_err), 64'(e.err));
          chk("latency", 64'(cyc - e.acc), 64'(e.lat));
          chk("memread_cycles", 64'(nrd_seen), 64'(e.nrd));
          chk("memwrite_cycles", 64'(nwr_seen), 64'(e.nwr));
        end
      end else begin
        chk("idle_quiet", 64'({resp_valid, MemRead, MemWrite}), 64'd0);
      end
      if (req_valid && req_ready) begin
        e = cur_exp;
        e.acc = cyc;
        q.push_back(e);
        nrd_seen = 0;
        nwr_seen = 0;
      end
    end
  end

  task automatic drive(input vec_t v);
    req_we       = v.we;
    req_size     = v.size;
    req_unsigned = v.uns;
    req_addr     = v.addr;
    req_wdata    = v.wdata;
    cur_exp      = mk_exp(v);
    req_valid    = 1'b1;
  endtask

  task automatic wait_accept();
    bit ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready && !reset) begin ok = 1'b1; break; end
    end
    chk("accept_in_time", 64'(ok), 64'd1);
    @(posedge clk); #2;
  endtask

  task automatic wait_done();
    bit ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (q.size() == 0) begin ok = 1'b1; break; end
    end
    chk("resp_in_time", 64'(ok), 64'd1);
    @(posedge clk); #2;
  endtask

  task automatic send(input vec_t v);
    drive(v);
    wait_accept();
    req_valid = 1'b0;
    wait_done();
  endtask

  initial begin
    // we, size, uns, addr, wdata, expected rdata, expected err
    tbl.push_back(mkv(1, 2'b11, 0, 10'h000, 64'h1122334455667788, 64'h0, 0));
    tbl.push_back(mkv(0, 2'b11, 0, 10'h000, 64'h0, 64'h1122334455667788, 0));
    tbl.push_back(mkv(0, 2'b00, 0, 10'h001, 64'h0, 64'h0000000000000022, 0));
    tbl.push_back(mkv(0, 2'b00, 0, 10'h007, 64'h0, 64'hFFFFFFFFFFFFFF88, 0));
    tbl.push_back(mkv(0, 2'b00, 1, 10'h007, 64'h0, 64'h0000000000000088, 0));
    tbl.push_back(mkv(1, 2'b01, 0, 10'h002, 64'h000000000000BEEF, 64'h0, 0));
    tbl.push_back(mkv(0, 2'b11, 0, 10'h000, 64'h0, 64'h1122BEEF55667788, 0));
    tbl.push_back(mkv(0, 2'b10, 0, 10'h004, 64'h0, 64'h0000000055667788, 0));
    tbl.push_back(mkv(0, 2'b01, 0, 10'h002, 64'h0, 64'hFFFFFFFFFFFFBEEF, 0));
    tbl.push_back(mkv(0, 2'b01, 1, 10'h002, 64'h0, 64'h000000000000BEEF, 0));
    tbl.push_back(mkv(1, 2'b11, 0, 10'h008, 64'h8090A0B0C0D0E0F0, 64'h0, 0));
    tbl.push_back(mkv(0, 2'b10, 0, 10'h008, 64'h0, 64'hFFFFFFFF8090A0B0, 0));
    tbl.push_back(mkv(0, 2'b10, 1, 10'h008, 64'h0, 64'h000000008090A0B0, 0));
    tbl.push_back(mkv(0, 2'b11, 1, 10'h008, 64'h0, 64'h8090A0B0C0D0E0F0, 0));
    tbl.push_back(mkv(1, 2'b00, 0, 10'h00F, 64'h00000000000001AA, 64'h0, 0));
    tbl.push_back(mkv(0, 2'b11, 0, 10'h008, 64'h0, 64'h8090A0B0C0D0E0AA, 0));
    tbl.push_back(mkv(1, 2'b10, 0, 10'h00C, 64'hFFFFFFFF12345678, 64'h0, 0));
    tbl.push_back(mkv(0, 2'b11, 0, 10'h008, 64'h0, 64'h8090A0B012345678, 0));
`ifdef LSU_ALIGN_CHECK_EN
    tbl.push_back(mkv(0, 2'b10, 0, 10'h002, 64'h0, 64'h0, 1));
    tbl.push_back(mkv(1, 2'b01, 0, 10'h011, 64'h7777, 64'h0, 1));
    tbl.push_back(mkv(0, 2'b11, 0, 10'h010, 64'h0, 64'h0, 0));
`else
    tbl.push_back(mkv(0, 2'b10, 0, 10'h002, 64'h0, 64'h000000001122BEEF, 0));
    tbl.push_back(mkv(1, 2'b01, 0, 10'h011, 64'h7777, 64'h0, 0));
    tbl.push_back(mkv(0, 2'b11, 0, 10'h010, 64'h0, 64'h7777000000000000, 0));
`endif
    tbl.push_back(mkv(1, 2'b00, 0, 10'h3FF, 64'h80, 64'h0, 0));
    tbl.push_back(mkv(0, 2'b00, 0, 10'h3FF, 64'h0, 64'hFFFFFFFFFFFFFF80, 0));
    tbl.push_back(mkv(0, 2'b11, 0, 10'h3F8, 64'h0, 64'h0000000000000080, 0));

    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = '0;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    cur_exp = mk_exp(mkv(0, 2'b00, 0, '0, '0, '0, 0));
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_resp", 64'({resp_valid, resp_err}), 64'd0);
    chk("rst_rdata", resp_rdata, 64'd0);
    chk("rst_mem_addr", 64'(mem_address), 64'd0);
    chk("rst_mem_wdata", mem_write_data, 64'd0);
    chk("rst_strobes", 64'({MemRead, MemWrite}), 64'd0);
    @(posedge clk); #2;

    for (int i = 0; i < tbl.size(); i++) send(tbl[i]);

    // Reset landing on the WRITE cycle of a byte store must abandon it without a commit.
    drive(mkv(1, 2'b00, 0, 10'h009, 64'hAA, 64'h0, 0));
    wait_accept();
    req_valid = 1'b0;
    @(posedge clk); #2;
    chk("pre_reset_in_write", 64'(MemWrite), 64'd1);
    reset = 1'b1;
    #1;
    chk("reset_gates_strobes", 64'({MemRead, MemWrite}), 64'd0);
    @(posedge clk); #2;
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 64'(req_ready), 64'd1);
    chk("no_resp_after_reset", 64'(resp_valid), 64'd0);
    repeat (4) @(negedge clk);
    chk("mem8_after_abort", mem[1], 64'h8090A0B012345678);
    @(posedge clk); #2;
    send(mkv(0, 2'b11, 0, 10'h008, 64'h0, 64'h8090A0B012345678, 0));

    // A second request held on req_valid while busy waits for IDLE, then gets its own response.
    drive(mkv(0, 2'b11, 0, 10'h008, 64'h0, 64'h8090A0B012345678, 0));
    wait_accept();
    drive(mkv(0, 2'b00, 1, 10'h009, 64'h0, 64'h0000000000000090, 0));
    wait_accept();
    req_valid = 1'b0;
    wait_done();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
